// File: rtl/mlaccel_spi_pkg.sv
// Shared opcodes, state encoding and decode helpers for the SPI command sequencer.
package mlaccel_spi_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_SRESET = 8'h04;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;
  localparam logic [2:0] ST_STATUS  = 3'd5;
  localparam logic [2:0] ST_DISCARD = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ADDR_HI = ST_ADDR_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_WRITE   = ST_WRITE,
    S_READ    = ST_READ,
    S_STATUS  = ST_STATUS,
    S_DISCARD = ST_DISCARD
  } cmd_state_t;

  // WRITE and READ are the only opcodes followed by a two-byte address.
  function automatic logic op_has_addr(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mlaccel_spi_cmd_if.sv
// Byte stream and buffer-memory port bundle between the SPI front end, sequencer and memory.
interface mlaccel_spi_cmd_if #(
  parameter int ADDR_BITS = 16
);
  logic                 din_valid;
  logic                 din_start;
  logic [7:0]           din_data;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [7:0]           dout_data;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_wen;
  logic [7:0]           mem_wdata;
  logic                 mem_ren;
  logic [7:0]           mem_rdata;

  modport slave (
    input  din_valid, din_start, din_data, dout_ready, mem_rdata,
    output dout_valid, dout_data, mem_addr, mem_wen, mem_wdata, mem_ren
  );

  modport master (
    output din_valid, din_start, din_data, dout_ready, mem_rdata,
    input  dout_valid, dout_data, mem_addr, mem_wen, mem_wdata, mem_ren
  );
endinterface

// File: rtl/mlaccel_spi_rdstage.sv
// One-entry transmit holding register with valid/ready handshake; load wins over flush.
module mlaccel_spi_rdstage (
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_flush,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);
  logic       r_valid;
  logic [7:0] r_data;

  // Data only changes on load, so it stays stable for the whole valid window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/mlaccel_spi_cmd.sv
// Frame parser and buffer-memory sequencer behind the mlaccel_spi byte interface.
module mlaccel_spi_cmd
  import mlaccel_spi_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int STATUS_W  = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                active,
  input  logic [STATUS_W-1:0] status,
  output logic                soft_reset,
  output logic                cmd_err,
  mlaccel_spi_cmd_if.slave    bus
);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  cmd_state_t           r_state, w_state_next;
  logic [7:0]           r_addr_hi, w_addr_hi_next;
  logic [ADDR_BITS-1:0] r_addr, w_addr_next;
  logic                 r_op_read, w_op_read_next;
  logic [ADDR_BITS-1:0] r_mem_addr, w_mem_addr_next;
  logic [7:0]           r_mem_wdata, w_mem_wdata_next;
  logic                 r_mem_wen, w_mem_wen_next;
  logic                 r_mem_ren, w_mem_ren_next;
  logic                 r_soft_reset, w_soft_reset_next;
  logic                 r_cmd_err, w_cmd_err_next;
  logic                 r_rd_pend, w_rd_pend_next;
  logic                 w_st_load, w_flush, w_rd_load, w_frame;
  logic                 w_dout_valid;
  logic [7:0]           w_dout_data;
  logic [15:0]          w_addr16;

  assign w_frame   = active && bus.din_valid && bus.din_start;
  assign w_addr16  = {r_addr_hi, bus.din_data};
  // mem_rdata is valid in the cycle after mem_ren; an abort in that cycle drops it.
  assign w_rd_load = r_rd_pend && active && !w_frame;

  always_comb begin
    w_state_next      = r_state;
    w_addr_hi_next    = r_addr_hi;
    w_addr_next       = r_addr;
    w_op_read_next    = r_op_read;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_mem_wen_next    = 1'b0;
    w_mem_ren_next    = 1'b0;
    w_soft_reset_next = 1'b0;
    w_cmd_err_next    = r_cmd_err;
    w_rd_pend_next    = r_mem_ren;
    w_st_load         = 1'b0;
    w_flush           = 1'b0;

    if (!active) begin
      w_state_next   = S_IDLE;
      w_rd_pend_next = 1'b0;
      w_flush        = 1'b1;
    end else if (w_frame) begin
      // A frame start is decoded as an opcode from any state, aborting the current command.
      w_cmd_err_next = 1'b0;
      w_rd_pend_next = 1'b0;
      w_flush        = 1'b1;
      if (op_has_addr(bus.din_data)) begin
        w_state_next   = S_ADDR_HI;
        w_op_read_next = (bus.din_data == OP_READ);
      end else if (bus.din_data == OP_STATUS) begin
        w_state_next = S_STATUS;
        w_st_load    = 1'b1;
      end else if (bus.din_data == OP_SRESET) begin
        w_state_next      = S_DISCARD;
        w_soft_reset_next = 1'b1;
      end else begin
        w_state_next   = S_DISCARD;
        w_cmd_err_next = 1'b1;
      end
    end else begin
      case (r_state)
        S_ADDR_HI: begin
          if (bus.din_valid) begin
            w_addr_hi_next = bus.din_data;
            w_state_next   = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (bus.din_valid) begin
            w_addr_next = w_addr16[ADDR_BITS-1:0];
            if (r_op_read) begin
              w_mem_ren_next  = 1'b1;
              w_mem_addr_next = w_addr16[ADDR_BITS-1:0];
              w_state_next    = S_READ;
            end else begin
              w_state_next = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (bus.din_valid) begin
            w_mem_wen_next   = 1'b1;
            w_mem_addr_next  = r_addr;
            w_mem_wdata_next = bus.din_data;
            w_addr_next      = r_addr + ADDR_ONE;
          end
        end
        S_READ: begin
          // Dummy din bytes are ignored; only the transmit handshake advances the stream.
          if (w_dout_valid && bus.dout_ready) begin
            w_addr_next     = r_addr + ADDR_ONE;
            w_mem_addr_next = r_addr + ADDR_ONE;
            w_mem_ren_next  = 1'b1;
          end
        end
        S_STATUS: begin
          if (w_dout_valid && bus.dout_ready) begin
            w_state_next = S_DISCARD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_addr_hi    <= 8'h00;
      r_addr       <= '0;
      r_op_read    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_mem_wen    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_soft_reset <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_rd_pend    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr_hi    <= w_addr_hi_next;
      r_addr       <= w_addr_next;
      r_op_read    <= w_op_read_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_wen    <= w_mem_wen_next;
      r_mem_ren    <= w_mem_ren_next;
      r_soft_reset <= w_soft_reset_next;
      r_cmd_err    <= w_cmd_err_next;
      r_rd_pend    <= w_rd_pend_next;
    end
  end

  mlaccel_spi_rdstage u_rdstage (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_st_load || w_rd_load),
    .i_data  (w_st_load ? status[7:0] : bus.mem_rdata),
    .i_flush (w_flush),
    .i_ready (bus.dout_ready),
    .o_valid (w_dout_valid),
    .o_data  (w_dout_data)
  );

  assign bus.dout_valid = w_dout_valid;
  assign bus.dout_data  = w_dout_data;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_ren    = r_mem_ren;
  assign soft_reset     = r_soft_reset;
  assign cmd_err        = r_cmd_err;
endmodule

// File: tb/tb_mlaccel_spi_cmd.sv
// Directed bench for mlaccel_spi_cmd: write/read/wrap/status/error/abort/reset sequences.
module tb_mlaccel_spi_cmd;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       active = 1'b0;
  logic [7:0] status = 8'h00;
  logic       soft_reset;
  logic       cmd_err;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clock = ~clock;

  mlaccel_spi_cmd_if #(.ADDR_BITS(16)) bus ();

  mlaccel_spi_cmd #(.ADDR_BITS(16), .STATUS_W(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .active     (active),
    .status     (status),
    .soft_reset (soft_reset),
    .cmd_err    (cmd_err),
    .bus        (bus)
  );

  // Memory model with one-cycle read latency plus activity logs.
  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          n_ren = 0;
  int          n_sr = 0;
  int          n_overlap = 0;

  always @(posedge clock) begin
    if (bus.mem_ren) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      n_ren <= n_ren + 1;
    end
    if (bus.mem_wen) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (soft_reset) n_sr <= n_sr + 1;
    if (bus.mem_wen && bus.mem_ren) n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    bus.din_valid = 1'b1;
    bus.din_start = st;
    bus.din_data  = b;
    tick(1);
    bus.din_valid = 1'b0;
    bus.din_start = 1'b0;
  endtask

  initial begin
    bus.din_valid  = 1'b0;
    bus.din_start  = 1'b0;
    bus.din_data   = 8'h00;
    bus.dout_ready = 1'b0;
    mem[16'h2000] = 8'h5A;
    mem[16'h2001] = 8'hC3;
    mem[16'h2002] = 8'h99;
    mem[16'h3000] = 8'h00;

    tick(2);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout_data",  32'(bus.dout_data),  32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wen",    32'(bus.mem_wen),    32'd0);
    chk("rst_mem_ren",    32'(bus.mem_ren),    32'd0);
    chk("rst_soft_reset", 32'(soft_reset),     32'd0);
    chk("rst_cmd_err",    32'(cmd_err),        32'd0);
    resetn = 1'b1;
    active = 1'b1;
    tick(2);

    // WRITE burst 01 12 34 AA BB CC
    send(8'h01, 1'b1); tick(2);
    send(8'h12, 1'b0); tick(2);
    send(8'h34, 1'b0); tick(2);
    send(8'hAA, 1'b0);
    chk("wr0_wen",   32'(bus.mem_wen),   32'd1);
    chk("wr0_addr",  32'(bus.mem_addr),  32'h1234);
    chk("wr0_wdata", 32'(bus.mem_wdata), 32'hAA);
    tick(1);
    chk("wr0_wen_pulse", 32'(bus.mem_wen), 32'd0);
    tick(1);
    send(8'hBB, 1'b0); tick(2);
    send(8'hCC, 1'b0); tick(2);
    chk("wr_count", 32'(wr_addr_q.size()), 32'd3);
    chk("wr1_addr", 32'(wr_addr_q[1]), 32'h1235);
    chk("wr1_data", 32'(wr_data_q[1]), 32'hBB);
    chk("wr2_addr", 32'(wr_addr_q[2]), 32'h1236);
    chk("wr2_data", 32'(wr_data_q[2]), 32'hCC);
    chk("wr_no_ren", 32'(n_ren), 32'd0);
    chk("wr_no_dout", 32'(bus.dout_valid), 32'd0);

    // READ 02 20 00 with dummies and handshakes
    send(8'h02, 1'b1); tick(2);
    send(8'h20, 1'b0); tick(2);
    send(8'h00, 1'b0);
    chk("rd_ren0",  32'(bus.mem_ren),  32'd1);
    chk("rd_addr0", 32'(bus.mem_addr), 32'h2000);
    tick(2);
    chk("rd_valid0", 32'(bus.dout_valid), 32'd1);
    chk("rd_data0",  32'(bus.dout_data),  32'h5A);
    send(8'h11, 1'b0);
    chk("rd_hold_valid", 32'(bus.dout_valid), 32'd1);
    chk("rd_hold_noren", 32'(bus.mem_ren),    32'd0);
    bus.dout_ready = 1'b1; tick(1); bus.dout_ready = 1'b0;
    chk("rd_hs0_valid", 32'(bus.dout_valid), 32'd0);
    chk("rd_ren1",      32'(bus.mem_ren),    32'd1);
    chk("rd_addr1",     32'(bus.mem_addr),   32'h2001);
    tick(2);
    chk("rd_valid1", 32'(bus.dout_valid), 32'd1);
    chk("rd_data1",  32'(bus.dout_data),  32'hC3);
    // Dummy byte and handshake in the same cycle: handshake wins.
    bus.din_valid = 1'b1; bus.din_data = 8'hFF; bus.dout_ready = 1'b1;
    tick(1);
    bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
    chk("rd_hs1_valid", 32'(bus.dout_valid), 32'd0);
    chk("rd_ren2",      32'(bus.mem_ren),    32'd1);
    chk("rd_addr2",     32'(bus.mem_addr),   32'h2002);
    tick(2);
    chk("rd_data2", 32'(bus.dout_data), 32'h99);
    // Abort with dout_valid pending: new opcode SRESET decoded at once.
    send(8'h04, 1'b1);
    chk("abort_valid", 32'(bus.dout_valid), 32'd0);
    chk("abort_sreset", 32'(soft_reset),    32'd1);
    tick(1);
    chk("abort_sreset_pulse", 32'(soft_reset), 32'd0);
    chk("rd_ren_total", 32'(n_ren), 32'd3);
    chk("rd_no_wen", 32'(wr_addr_q.size()), 32'd3);

    // Address wrap
    send(8'h01, 1'b1); tick(2);
    send(8'hFF, 1'b0); tick(2);
    send(8'hFF, 1'b0); tick(2);
    send(8'h11, 1'b0); tick(2);
    send(8'h22, 1'b0); tick(2);
    chk("wrap_count", 32'(wr_addr_q.size()), 32'd5);
    chk("wrap_addr0", 32'(wr_addr_q[3]), 32'hFFFF);
    chk("wrap_data0", 32'(wr_data_q[3]), 32'h11);
    chk("wrap_addr1", 32'(wr_addr_q[4]), 32'h0000);
    chk("wrap_data1", 32'(wr_data_q[4]), 32'h22);

    // STATUS
    status = 8'h81;
    send(8'h03, 1'b1);
    chk("st_valid", 32'(bus.dout_valid), 32'd1);
    chk("st_data",  32'(bus.dout_data),  32'h81);
    tick(3);
    chk("st_held", 32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1; tick(1); bus.dout_ready = 1'b0;
    chk("st_done", 32'(bus.dout_valid), 32'd0);
    tick(3);
    chk("st_no_more", 32'(bus.dout_valid), 32'd0);

    // Unknown opcode, then SRESET clears the error
    send(8'h7E, 1'b1);
    chk("unk_err", 32'(cmd_err), 32'd1);
    tick(2);
    send(8'h55, 1'b0); tick(2);
    chk("unk_err_sticky", 32'(cmd_err), 32'd1);
    chk("unk_no_wr", 32'(wr_addr_q.size()), 32'd5);
    chk("unk_no_rd", 32'(n_ren), 32'd3);
    send(8'h04, 1'b1);
    chk("sr_err_clr", 32'(cmd_err),    32'd0);
    chk("sr_pulse",   32'(soft_reset), 32'd1);
    tick(1);
    chk("sr_pulse_end", 32'(soft_reset), 32'd0);
    chk("sr_total", 32'(n_sr), 32'd2);

    // cmd_err held across an inactive period
    send(8'h7E, 1'b1);
    active = 1'b0; tick(2); active = 1'b1; tick(1);
    chk("inact_err_held", 32'(cmd_err), 32'd1);

    // active dropped mid-WRITE
    send(8'h01, 1'b1); tick(2);
    chk("wr2_err_clr", 32'(cmd_err), 32'd0);
    send(8'h30, 1'b0); tick(2);
    send(8'h00, 1'b0); tick(2);
    send(8'h01, 1'b0);
    chk("act_wen", 32'(bus.mem_wen), 32'd1);
    active = 1'b0; tick(1); active = 1'b1; tick(1);
    send(8'h02, 1'b0);
    chk("act_no_wen", 32'(bus.mem_wen), 32'd0);
    tick(2);
    chk("act_wr_count", 32'(wr_addr_q.size()), 32'd6);

    // resetn mid-READ
    send(8'h02, 1'b1); tick(2);
    send(8'h20, 1'b0); tick(2);
    send(8'h01, 1'b0); tick(2);
    chk("rr_valid", 32'(bus.dout_valid), 32'd1);
    chk("rr_data",  32'(bus.dout_data),  32'hC3);
    resetn = 1'b0;
    #1;
    chk("rr_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rr_dout_data",  32'(bus.dout_data),  32'd0);
    chk("rr_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rr_mem_ren",    32'(bus.mem_ren),    32'd0);
    chk("rr_cmd_err",    32'(cmd_err),        32'd0);
    tick(2);
    resetn = 1'b1;
    tick(2);
    chk("no_wen_ren_overlap", 32'(n_overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
